baccarat_seq: RTL

BACCARAT_SEQ -- requirements
Module: baccarat_seq

---
 rtl/baccarat_seq.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/baccarat_seq.sv
// ---------------------------------------------------------------------------
// baccarat_seq
//
// Purpose:
//   Sequencer for one hand of Baccarat. A Moore FSM walks through the
//   initial four-card deal, decides whether the player and/or the dealer
//   draw a third card, and then registers the result lights. An external
//   card datapath holds the cards and reports the running hand scores.
//
// Optional feature (macro BACCARAT_AUTO_RESTART_EN):
//   When defined, DONE is held for RESTART_CYCLES cycles. The FSM then
//   enters CLEAR, which pulses clear_hands and clears the lights, and
//   returns to DEAL_P1 to start a new hand. When undefined, the FSM stays
//   in DONE until reset and clear_hands is tied low.
//
// Parameters:
//   RESTART_CYCLES : cycles spent in DONE before auto-restart (macro only)
//
// Ports:
//   slow_clock       in   sole clock, rising edge
//   resetb           in   asynchronous active-low reset
//   pscore[3:0]      in   player hand score 0-9
//   dscore[3:0]      in   dealer hand score 0-9
//   pcard3[3:0]      in   player third-card rank 1-13
//   load_pcard1..3   out  one-cycle strobes, load a player card register
//   load_dcard1..3   out  one-cycle strobes, load a dealer card register
//   clear_hands      out  one-cycle strobe, clear all card registers
//   player_win_light out  registered result light
//   dealer_win_light out  registered result light
//   dbg_state[3:0]   out  current FSM state, for observation only
//
// Handshake: there is no valid/ready pairing. Each load strobe is high for
//   exactly the one cycle the FSM spends in its DEAL_* state; the datapath
//   loads on the rising edge that ends that cycle, and the resulting scores
//   are treated as valid from the following cycle.
// ---------------------------------------------------------------------------
module baccarat_seq #(
    parameter int RESTART_CYCLES = 8
) (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       clear_hands,
    output logic       player_win_light,
    output logic       dealer_win_light,
    output logic [3:0] dbg_state
);

    typedef enum logic [3:0] {
        DEAL_P1 = 4'd0,
        DEAL_D1 = 4'd1,
        DEAL_P2 = 4'd2,
        DEAL_D2 = 4'd3,
        EVAL    = 4'd4,
        DEAL_P3 = 4'd5,
        BANK    = 4'd6,
        DEAL_D3 = 4'd7,
        SCORE   = 4'd8,
        DONE    = 4'd9
`ifdef BACCARAT_AUTO_RESTART_EN
        ,
        CLEAR   = 4'd10
`endif
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] w_v;
    logic       w_bank_draw;
    logic       r_player_win;
    logic       r_dealer_win;

`ifdef BACCARAT_AUTO_RESTART_EN
    localparam int CW = $clog2(RESTART_CYCLES + 1);
    logic [CW-1:0] r_cnt;
    logic          w_cnt_last;

    assign w_cnt_last = (r_cnt == CW'(RESTART_CYCLES - 1));
`endif

    // Third-card value: ten and face cards count zero.
    assign w_v = (pcard3 <= 4'd9) ? pcard3 : 4'd0;

    // Dealer third-card drawing table, used only after the player drew.
    always_comb begin
        w_bank_draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: w_bank_draw = 1'b1;
            4'd3:             w_bank_draw = (w_v != 4'd8);
            4'd4:             w_bank_draw = (w_v >= 4'd2) && (w_v <= 4'd7);
            4'd5:             w_bank_draw = (w_v >= 4'd4) && (w_v <= 4'd7);
            4'd6:             w_bank_draw = (w_v >= 4'd6) && (w_v <= 4'd7);
            default:          w_bank_draw = 1'b0;
        endcase
    end

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            r_state <= DEAL_P1;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            DEAL_P1: w_next = DEAL_D1;
            DEAL_D1: w_next = DEAL_P2;
            DEAL_P2: w_next = DEAL_D2;
            DEAL_D2: w_next = EVAL;
            EVAL: begin
                // Out-of-range scores (>9) fall into the natural branch.
                if ((pscore >= 4'd8) || (dscore >= 4'd8)) begin
                    w_next = SCORE;
                end else if (pscore <= 4'd5) begin
                    w_next = DEAL_P3;
                end else if (dscore <= 4'd5) begin
                    w_next = DEAL_D3;
                end else begin
                    w_next = SCORE;
                end
            end
            DEAL_P3: w_next = BANK;
            BANK:    w_next = w_bank_draw ? DEAL_D3 : SCORE;
            DEAL_D3: w_next = SCORE;
            SCORE:   w_next = DONE;
`ifdef BACCARAT_AUTO_RESTART_EN
            DONE:    w_next = w_cnt_last ? CLEAR : DONE;
            CLEAR:   w_next = DEAL_P1;
`else
            DONE:    w_next = DONE;
`endif
            default: w_next = DEAL_P1;
        endcase
    end

`ifdef BACCARAT_AUTO_RESTART_EN
    // Counter is zero whenever the FSM is outside DONE, so it starts from
    // zero on every DONE entry.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            r_cnt <= '0;
        end else if (r_state != DONE) begin
            r_cnt <= '0;
        end else if (!w_cnt_last) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`endif

    // Lights are captured on the edge leaving SCORE; a tie lights both.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            r_player_win <= 1'b0;
            r_dealer_win <= 1'b0;
        end else if (r_state == SCORE) begin
            r_player_win <= (pscore >= dscore);
            r_dealer_win <= (dscore >= pscore);
`ifdef BACCARAT_AUTO_RESTART_EN
        end else if ((r_state == DONE) && w_cnt_last) begin
            // Cleared on entry to CLEAR so they read low alongside clear_hands.
            r_player_win <= 1'b0;
            r_dealer_win <= 1'b0;
`endif
        end
    end

    // Strobes are gated by resetb so that all outputs read low during
    // reset even though the reset state is DEAL_P1.
    assign load_pcard1 = resetb && (r_state == DEAL_P1);
    assign load_dcard1 = resetb && (r_state == DEAL_D1);
    assign load_pcard2 = resetb && (r_state == DEAL_P2);
    assign load_dcard2 = resetb && (r_state == DEAL_D2);
    assign load_pcard3 = resetb && (r_state == DEAL_P3);
    assign load_dcard3 = resetb && (r_state == DEAL_D3);

`ifdef BACCARAT_AUTO_RESTART_EN
    assign clear_hands = resetb && (r_state == CLEAR);
`else
    assign clear_hands = 1'b0;
`endif

    assign player_win_light = r_player_win;
    assign dealer_win_light = r_dealer_win;
    assign dbg_state        = r_state;

endmodule
